user_locked_regfile: RTL and testbench
======================================

// Module: user_locked_regfile
// PURPOSE
//  Parametrised bank of NUM_REGS user-locked registers: writes accepted only from AUTH_ID, rejected writes
//  leave contents unchanged. Adds per-register sticky lock, violation counting and a timed global lockout.
//  Sits between the bus decoder and config consumers; each register drives its q_out slice continuously.
// PARAMETERS
//  DATA_W        8     width of each register
//  NUM_REGS      4     number of registers (>=2); ADDR_W = $clog2(NUM_REGS)
//  ID_W          2     width of usr_id
//  AUTH_ID       2     only ID allowed to write/lock
//  RESET_VAL     0     reset value of every register (DATA_W bits)
//  MAX_VIOL      3     rejected attempts that trigger lockout (1..255)
//  LOCKOUT_CYC   16    lockout duration in clk cycles (>=1)
// PORTS
//  clk        in   1                 clock, all logic on posedge
//  rst        in   1                 synchronous active-high reset
//  usr_id     in   ID_W              requester ID, sampled with wr_en/lock_en/rd_en
//  wr_en      in   1                 write request
//  lock_en    in   1                 lock request for register wr_addr
//  wr_addr    in   ADDR_W            target register for write/lock
//  wr_data    in   DATA_W            write data
//  rd_en      in   1                 read request
//  rd_addr    in   ADDR_W            read address
//  rd_data    out  DATA_W            read data, valid with rd_valid
//  rd_valid   out  1                 1-cycle pulse, read response
//  wr_ack     out  1                 1-cycle pulse, write/lock accepted
//  wr_err     out  1                 1-cycle pulse, write/lock rejected
//  locked     out  NUM_REGS          per-register sticky lock bits
//  lockout    out  1                 high while in LOCKOUT state
//  q_out      out  NUM_REGS*DATA_W   all register contents, reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides everything): regs=RESET_VAL, locked=0, viol_cnt=0, state=OPEN,
//   rd_data=0, rd_valid=0, wr_ack=0, wr_err=0, lockout=0. Reset mid-lockout returns to OPEN at once.
//  Request = wr_en|lock_en. Response (wr_ack xor wr_err) registered 1 cycle after request; no stalls.
//  Accept iff state==OPEN, usr_id==AUTH_ID, locked[wr_addr]==0, wr_addr<NUM_REGS. Otherwise reject.
//  Accepted write: reg[wr_addr]<=wr_data. Accepted lock: locked[wr_addr]<=1 (sticky until rst).
//  wr_en and lock_en same cycle, accepted: data written AND lock set in that edge; one wr_ack.
//  Rejected request: no register/lock change (never overwrite with constant); wr_err=1.
//  Violation = rejected request with usr_id!=AUTH_ID, or AUTH_ID writing a locked reg, in OPEN.
//   Each violation: viol_cnt+1; when it reaches MAX_VIOL, next state LOCKOUT, viol_cnt<=0.
//   Requests during LOCKOUT: wr_err=1, not counted. Accepted write does not clear viol_cnt.
//  FSM: OPEN -> LOCKOUT on MAX_VIOL-th violation; LOCKOUT loads timer=LOCKOUT_CYC-1, decrements
//   each cycle; LOCKOUT -> OPEN on cycle timer==0. Lockout lasts exactly LOCKOUT_CYC cycles.
//  lockout output = (state==LOCKOUT), registered.
//  Reads: any usr_id; rd_data<=reg[rd_addr], rd_valid<=1 one cycle after rd_en; reads allowed in
//   LOCKOUT. Out-of-range rd_addr returns 0. Read and write same addr same cycle: old value.
//  q_out reflects register state directly (0-cycle from flop). No other latency anywhere.
// TESTING
//  1 rst; rd all regs -> rd_data==RESET_VAL, locked==0, lockout==0.
//  2 usr_id=2 wr addr1 0xA5 -> wr_ack next cycle, q_out[15:8]==0xA5; usr_id=1 wr 0x3C -> wr_err, stays 0xA5.
//  3 usr_id=2 lock addr1 -> locked[1]=1; usr_id=2 wr 0x11 -> wr_err, value 0xA5; addr0 still writable.
//  4 three usr_id=0 writes -> 3 wr_err, lockout high for exactly 16 cycles; auth write inside -> wr_err,
//    after lockout falls auth write -> wr_ack.
//  5 rst asserted on 5th lockout cycle -> next cycle lockout=0, locked=0, regs=RESET_VAL, viol_cnt=0.
//  6 wr_en+lock_en auth same cycle addr2 0x7E -> one wr_ack, reg2=0x7E, locked[2]=1; rd same addr same cycle old.

Source files
------------

// File: rtl/user_locked_regfile.sv
// Bank of NUM_REGS registers. Only AUTH_ID may write or lock them. Each register has a sticky
// lock bit. Rejected requests are counted as violations, and reaching MAX_VIOL of them starts a
// timed global lockout.
module user_locked_regfile #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       NUM_REGS    = 4,
    parameter int unsigned       ID_W        = 2,
    parameter int unsigned       AUTH_ID     = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0,
    parameter int unsigned       MAX_VIOL    = 3,
    parameter int unsigned       LOCKOUT_CYC = 16,
    localparam int unsigned      ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_W-1:0]            usr_id,
    input  logic                       wr_en,
    input  logic                       lock_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic [NUM_REGS-1:0]        locked,
    output logic                       lockout,
    output logic [NUM_REGS*DATA_W-1:0] q_out
);

    localparam int unsigned VIOL_W = 8;
    localparam int unsigned TMR_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    typedef enum logic {
        ST_OPEN    = 1'b0,
        ST_LOCKOUT = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [VIOL_W-1:0]          viol_cnt_q, viol_cnt_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]        locked_q, locked_d;
    logic [DATA_W-1:0]          rd_data_q, rd_data_d;
    logic                       rd_valid_q, rd_valid_d;
    logic                       wr_ack_q, wr_ack_d;
    logic                       wr_err_q, wr_err_d;
    logic                       lockout_q, lockout_d;

    logic                       wr_hit;
    logic                       wr_tgt_locked;
    logic [DATA_W-1:0]          rd_val;
    logic                       req;
    logic                       is_auth;
    logic                       accept;
    logic                       violation;
    logic [VIOL_W-1:0]          viol_inc;

    // Address decode: a write target must be in range. An out-of-range read returns zero.
    always_comb begin
        wr_hit        = 1'b0;
        wr_tgt_locked = 1'b0;
        rd_val        = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                wr_hit        = 1'b1;
                wr_tgt_locked = locked_q[i];
            end
            if (rd_addr == ADDR_W'(i)) begin
                rd_val = regs_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Request qualification and violation classification
    always_comb begin
        req       = wr_en | lock_en;
        is_auth   = (usr_id == ID_W'(AUTH_ID));
        accept    = (state_q == ST_OPEN) & is_auth & wr_hit & ~wr_tgt_locked;
        violation = (state_q == ST_OPEN) & req & ~accept & (~is_auth | wr_tgt_locked);
        viol_inc  = viol_cnt_q + VIOL_W'(1);
    end

    // Next-state logic: register/lock updates, lockout FSM, registered responses
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        viol_cnt_d = viol_cnt_q;
        regs_d     = regs_q;
        locked_d   = locked_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        wr_ack_d   = req & accept;
        wr_err_d   = req & ~accept;

        if (rd_en) begin
            rd_data_d = rd_val;
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            if (req && accept && (wr_addr == ADDR_W'(i))) begin
                if (wr_en) begin
                    regs_d[i*DATA_W +: DATA_W] = wr_data;
                end
                if (lock_en) begin
                    locked_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            ST_OPEN: begin
                if (violation) begin
                    if (viol_inc == VIOL_W'(MAX_VIOL)) begin
                        state_d    = ST_LOCKOUT;
                        timer_d    = TMR_W'(LOCKOUT_CYC - 1);
                        viol_cnt_d = '0;
                    end else begin
                        viol_cnt_d = viol_inc;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_OPEN;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = ST_OPEN;
        endcase

        lockout_d = (state_d == ST_LOCKOUT);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_OPEN;
            timer_q    <= '0;
            viol_cnt_q <= '0;
            regs_q     <= {NUM_REGS{RESET_VAL}};
            locked_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            viol_cnt_q <= viol_cnt_d;
            regs_q     <= regs_d;
            locked_q   <= locked_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
            lockout_q  <= lockout_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_ack   = wr_ack_q;
    assign wr_err   = wr_err_q;
    assign locked   = locked_q;
    assign lockout  = lockout_q;
    assign q_out    = regs_q;

endmodule

// File: tb/tb_user_locked_regfile.sv
// Testbench for user_locked_regfile. Directed scenarios and random traffic are checked against
// a cycle-level reference model of the access, lock and lockout rules.
module tb_user_locked_regfile;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned NUM_REGS    = 4;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned AUTH_ID     = 2;
    localparam int unsigned MAX_VIOL    = 3;
    localparam int unsigned LOCKOUT_CYC = 16;
    localparam int unsigned ADDR_W      = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic [ID_W-1:0]            usr_id;
    logic                       wr_en, lock_en, rd_en;
    logic [ADDR_W-1:0]          wr_addr, rd_addr;
    logic [DATA_W-1:0]          wr_data, rd_data;
    logic                       rd_valid, wr_ack, wr_err, lockout;
    logic [NUM_REGS-1:0]        locked;
    logic [NUM_REGS*DATA_W-1:0] q_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_regs[NUM_REGS];
    bit m_locked[NUM_REGS];
    int m_viol;
    int m_left;
    bit e_ack, e_err, e_rv, e_lockout;
    int e_rd;

    user_locked_regfile #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ID_W(ID_W), .AUTH_ID(AUTH_ID),
        .RESET_VAL(8'h00), .MAX_VIOL(MAX_VIOL), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .usr_id(usr_id), .wr_en(wr_en), .lock_en(lock_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_ack(wr_ack), .wr_err(wr_err),
        .locked(locked), .lockout(lockout), .q_out(q_out)
    );

    function automatic logic [NUM_REGS*DATA_W-1:0] m_q();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = DATA_W'(m_regs[i]);
        return v;
    endfunction

    function automatic logic [NUM_REGS-1:0] m_lk();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_locked[i];
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model across the same edge, and settle 1 time unit past it.
    task automatic drive(input bit r, input int id, input bit we, input bit le, input int wa,
                         input int wd, input bit re, input int ra);
        bit open, req, auth, in_rng, lk, acc, viol;
        rst = r; usr_id = ID_W'(id); wr_en = we; lock_en = le; wr_addr = ADDR_W'(wa);
        wr_data = DATA_W'(wd); rd_en = re; rd_addr = ADDR_W'(ra);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < NUM_REGS; i++) begin m_regs[i] = 0; m_locked[i] = 0; end
            m_viol = 0; m_left = 0;
            e_ack = 0; e_err = 0; e_rv = 0; e_rd = 0; e_lockout = 0;
        end else begin
            open   = (m_left == 0);
            req    = we || le;
            auth   = (id == AUTH_ID);
            in_rng = (wa < NUM_REGS);
            lk     = in_rng && m_locked[wa];
            acc    = open && auth && in_rng && !lk;
            viol   = open && req && !acc && (!auth || lk);
            e_ack  = req && acc;
            e_err  = req && !acc;
            e_rv   = re;
            if (re) e_rd = (ra < NUM_REGS) ? m_regs[ra] : 0;
            if (req && acc) begin
                if (we) m_regs[wa] = wd & 8'hFF;
                if (le) m_locked[wa] = 1;
            end
            if (!open) m_left--;
            else if (viol) begin
                m_viol++;
                if (m_viol == MAX_VIOL) begin m_left = LOCKOUT_CYC; m_viol = 0; end
            end
            e_lockout = (m_left > 0);
        end
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++; if (lockout !== 1'b0) begin miscompares++; $display("FAIL rst_lockout: got %b want 0", lockout); end
        vectors++; if (locked !== '0) begin miscompares++; $display("FAIL rst_locked: got %b want 0", locked); end
        vectors++; if ({wr_ack, wr_err, rd_valid} !== 3'b000) begin miscompares++; $display("FAIL rst_pulses: got %b want 000", {wr_ack, wr_err, rd_valid}); end
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(0, $urandom_range(0, 3), 0, 0, 0, 0, 1, i);
            vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin miscompares++; $display("FAIL rst_read%0d: got v=%b d=%h want v=1 d=00", i, rd_valid, rd_data); end
        end
    endtask

    task automatic test_auth_write();
        drive(0, 2, 1, 0, 1, 8'hA5, 0, 0);
        vectors++; if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin miscompares++; $display("FAIL auth_ack: got ack=%b err=%b want 1/0", wr_ack, wr_err); end
        vectors++; if (q_out[15:8] !== 8'hA5) begin miscompares++; $display("FAIL auth_data: got %h want a5", q_out[15:8]); end
        drive(0, 1, 1, 0, 1, 8'h3C, 0, 0);
        vectors++; if (wr_err !== 1'b1 || wr_ack !== 1'b0) begin miscompares++; $display("FAIL unauth_err: got ack=%b err=%b want 0/1", wr_ack, wr_err); end
        idle();
        vectors++; if (q_out[15:8] !== 8'hA5) begin miscompares++; $display("FAIL unauth_keep: got %h want a5", q_out[15:8]); end
    endtask

    task automatic test_lock();
        drive(0, 2, 0, 1, 1, 0, 0, 0);
        vectors++; if (wr_ack !== 1'b1 || locked[1] !== 1'b1) begin miscompares++; $display("FAIL lock_set: got ack=%b locked=%b want 1/x1x", wr_ack, locked); end
        drive(0, 2, 1, 0, 1, 8'h11, 0, 0);
        vectors++; if (wr_err !== 1'b1 || q_out[15:8] !== 8'hA5) begin miscompares++; $display("FAIL lock_block: got err=%b d=%h want 1/a5", wr_err, q_out[15:8]); end
        drive(0, 2, 1, 0, 0, 8'h42, 0, 0);
        vectors++; if (wr_ack !== 1'b1 || q_out[7:0] !== 8'h42) begin miscompares++; $display("FAIL lock_other: got ack=%b d=%h want 1/42", wr_ack, q_out[7:0]); end
    endtask

    task automatic test_lockout();
        int n;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 3, $urandom_range(1, 255), 0, 0);
            vectors++; if (wr_err !== 1'b1) begin miscompares++; $display("FAIL viol_err%0d: got %b want 1", k, wr_err); end
        end
        vectors++; if (lockout !== 1'b1) begin miscompares++; $display("FAIL lockout_rise: got %b want 1", lockout); end
        n = (lockout === 1'b1) ? 1 : 0;
        for (int k = 0; k < 100 && lockout === 1'b1; k++) begin
            if (k == 4) begin
                drive(0, 2, 1, 0, 0, 8'h55, 0, 0);
                vectors++; if (wr_err !== 1'b1 || q_out[7:0] !== 8'h00) begin miscompares++; $display("FAIL lockout_reject: got err=%b d=%h want 1/00", wr_err, q_out[7:0]); end
            end else begin
                idle();
            end
            vectors++; if (lockout !== e_lockout) begin miscompares++; $display("FAIL lockout_track: got %b want %b", lockout, e_lockout); end
            if (lockout === 1'b1) n++;
        end
        vectors++; if (n != LOCKOUT_CYC) begin miscompares++; $display("FAIL lockout_len: got %0d want %0d", n, LOCKOUT_CYC); end
        drive(0, 2, 1, 0, 0, 8'h66, 0, 0);
        vectors++; if (wr_ack !== 1'b1 || q_out[7:0] !== 8'h66) begin miscompares++; $display("FAIL post_lockout: got ack=%b d=%h want 1/66", wr_ack, q_out[7:0]); end
    endtask

    task automatic test_reset_mid_lockout();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 2, 1, 0, 1, 8'h99, 0, 0);
        drive(0, 2, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 1, 1, 0, 2, 8'h01, 0, 0);
        for (int k = 0; k < 4; k++) idle();
        vectors++; if (lockout !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got %b want 1", lockout); end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        vectors++; if (lockout !== 1'b0 || locked !== '0) begin miscompares++; $display("FAIL mid_rst: got lockout=%b locked=%b want 0/0", lockout, locked); end
        vectors++; if (q_out !== '0) begin miscompares++; $display("FAIL mid_regs: got %h want 0", q_out); end
        drive(0, 0, 1, 0, 1, 8'h01, 0, 0);
        drive(0, 0, 1, 0, 1, 8'h02, 0, 0);
        vectors++; if (lockout !== 1'b0) begin miscompares++; $display("FAIL mid_cnt_clear: got %b want 0", lockout); end
        drive(0, 0, 1, 0, 1, 8'h03, 0, 0);
        vectors++; if (lockout !== 1'b1) begin miscompares++; $display("FAIL mid_cnt_third: got %b want 1", lockout); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 2, 1, 0, 2, 8'h33, 0, 0);
        drive(0, 2, 1, 1, 2, 8'h7E, 1, 2);
        vectors++; if ({wr_ack, wr_err} !== 2'b10) begin miscompares++; $display("FAIL wl_ack: got ack=%b err=%b want 1/0", wr_ack, wr_err); end
        vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'h33) begin miscompares++; $display("FAIL wl_old_read: got v=%b d=%h want 1/33", rd_valid, rd_data); end
        vectors++; if (q_out[23:16] !== 8'h7E || locked[2] !== 1'b1) begin miscompares++; $display("FAIL wl_state: got d=%h locked=%b want 7e/x1xx", q_out[23:16], locked); end
        drive(0, 2, 1, 0, 2, 8'h01, 0, 0);
        vectors++; if (wr_err !== 1'b1 || q_out[23:16] !== 8'h7E) begin miscompares++; $display("FAIL wl_sticky: got err=%b d=%h want 1/7e", wr_err, q_out[23:16]); end
    endtask

    task automatic test_random();
        int id;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            id = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : AUTH_ID;
            drive($urandom_range(0, 149) == 0, id, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 3));
            vectors++; if ({wr_ack, wr_err} !== {e_ack, e_err}) begin miscompares++; $display("FAIL rnd_resp@%0d: got %b%b want %b%b", k, wr_ack, wr_err, e_ack, e_err); end
            vectors++; if (rd_valid !== e_rv || (e_rv && rd_data !== DATA_W'(e_rd))) begin miscompares++; $display("FAIL rnd_read@%0d: got v=%b d=%h want v=%b d=%h", k, rd_valid, rd_data, e_rv, DATA_W'(e_rd)); end
            vectors++; if (lockout !== e_lockout) begin miscompares++; $display("FAIL rnd_lockout@%0d: got %b want %b", k, lockout, e_lockout); end
            vectors++; if (locked !== m_lk() || q_out !== m_q()) begin miscompares++; $display("FAIL rnd_state@%0d: got l=%b q=%h want l=%b q=%h", k, locked, q_out, m_lk(), m_q()); end
        end
    endtask

    initial begin
        test_reset();
        test_auth_write();
        test_lock();
        test_lockout();
        test_reset_mid_lockout();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
